// File: rtl/vga_timing_core.sv
// -----------------------------------------------------------------------------
// vga_timing_core
//
// Purpose:
//   VGA raster timing generator. A horizontal pixel counter and a vertical
//   line counter walk the frame in the order sync, back porch, active area,
//   front porch. They advance only on clock edges where pix_en_i is high.
//   Raw sync and display-enable flags are decoded from the counters. These
//   flags pass through a PIPE-deep delay line, so the frame source has PIPE
//   pixel steps to turn the address into a colour. The flags are then
//   registered onto the sync, display-enable and colour outputs.
//
// Ports:
//   clk_i         single clock for all logic
//   reset_n_i     synchronous active-low reset (has priority over pix_en_i)
//   pix_en_i      pixel-rate enable; all timing advances only when high
//   color_in_i    pixel colour from the frame source (COLOR_W bits)
//   color_out_o   registered colour to the DAC, 0 while blanked
//   addrh_o       active-area column, combinational from the counters
//   addrv_o       active-area row, combinational from the counters
//   addr_valid_o  high while addrh_o/addrv_o address a visible pixel
//   hs_o, vs_o    registered sync outputs, polarity set by HS_POL/VS_POL
//   de_o          registered display enable, aligned with color_out_o
//   refresh_o     one-clock pulse on the pixel step that wraps the frame
//   frame_cnt_o   8-bit frame counter, wraps 255 -> 0
// -----------------------------------------------------------------------------
module vga_timing_core #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int COLOR_W  = 12,
  parameter int PIPE     = 1
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               pix_en_i,
  input  logic [COLOR_W-1:0] color_in_i,
  output logic [COLOR_W-1:0] color_out_o,
  output logic [9:0]         addrh_o,
  output logic [9:0]         addrv_o,
  output logic               addr_valid_o,
  output logic               hs_o,
  output logic               vs_o,
  output logic               de_o,
  output logic               refresh_o,
  output logic [7:0]         frame_cnt_o
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  // Counters are 12 bits wide. A total of 2048 then still has an exclusive
  // end bound that fits without overflowing.
  localparam logic [11:0] H_LAST      = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST      = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_SYNC_END  = 12'(H_SYNC);
  localparam logic [11:0] V_SYNC_END  = 12'(V_SYNC);
  localparam logic [11:0] H_ACT_START = 12'(H_SYNC + H_BP);
  localparam logic [11:0] V_ACT_START = 12'(V_SYNC + V_BP);
  localparam logic [11:0] H_ACT_END   = 12'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [11:0] V_ACT_END   = 12'(V_SYNC + V_BP + V_ACTIVE);

  logic [11:0]        hCnt_q, hCnt_d;
  logic [11:0]        vCnt_q, vCnt_d;
  logic               hs_q, vs_q, de_q, refresh_q;
  logic [COLOR_W-1:0] color_q;
  logic [7:0]         frame_q;

  logic hLast, vLast, frameWrap;
  logic hActive, vActive;
  // Flag bundles are {hs, vs, de}. Each bit is 1 when that condition is active.
  logic [2:0] rawSync, lastSync;

  // Counter next-state logic. The vertical counter steps only when a line ends.
  always_comb begin
    hLast     = (hCnt_q == H_LAST);
    vLast     = (vCnt_q == V_LAST);
    frameWrap = hLast && vLast;
    hCnt_d    = hLast ? 12'd0 : hCnt_q + 12'd1;
    vCnt_d    = vCnt_q;
    if (hLast) begin
      vCnt_d = vLast ? 12'd0 : vCnt_q + 12'd1;
    end
  end

  // Raw decode of the current counter position, and the combinational
  // address the frame source uses to fetch the pixel for this position.
  always_comb begin
    hActive      = (hCnt_q >= H_ACT_START) && (hCnt_q < H_ACT_END);
    vActive      = (vCnt_q >= V_ACT_START) && (vCnt_q < V_ACT_END);
    rawSync      = {(hCnt_q < H_SYNC_END), (vCnt_q < V_SYNC_END), hActive && vActive};
    addr_valid_o = hActive && vActive;
    addrh_o      = '0;
    addrv_o      = '0;
    if (hActive && vActive) begin
      addrh_o = 10'(hCnt_q - H_ACT_START);
      addrv_o = 10'(vCnt_q - V_ACT_START);
    end
  end

  // Delay line that covers the frame source's fetch latency. Reset clears it
  // to the inactive state, so the first PIPE steps after reset are blanked.
  if (PIPE == 0) begin : gNoPipe
    assign lastSync = rawSync;
  end else begin : gPipe
    logic [2:0] pipe_q [PIPE];
    always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
        for (int i = 0; i < PIPE; i++) pipe_q[i] <= 3'b000;
      end else if (pix_en_i) begin
        pipe_q[0] <= rawSync;
        for (int i = 1; i < PIPE; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end
    assign lastSync = pipe_q[PIPE-1];
  end

  // Counters and registered outputs. refresh_q defaults low on every clock,
  // so it is exactly one clock wide even when pix_en_i stays high.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      hCnt_q    <= '0;
      vCnt_q    <= '0;
      hs_q      <= ~HS_POL;
      vs_q      <= ~VS_POL;
      de_q      <= 1'b0;
      color_q   <= '0;
      refresh_q <= 1'b0;
      frame_q   <= '0;
    end else begin
      refresh_q <= 1'b0;
      if (pix_en_i) begin
        hCnt_q    <= hCnt_d;
        vCnt_q    <= vCnt_d;
        hs_q      <= lastSync[2] ? HS_POL : ~HS_POL;
        vs_q      <= lastSync[1] ? VS_POL : ~VS_POL;
        de_q      <= lastSync[0];
        color_q   <= lastSync[0] ? color_in_i : '0;
        refresh_q <= frameWrap;
        if (frameWrap) frame_q <= frame_q + 8'd1;
      end
    end
  end

  assign hs_o        = hs_q;
  assign vs_o        = vs_q;
  assign de_o        = de_q;
  assign color_out_o = color_q;
  assign refresh_o   = refresh_q;
  assign frame_cnt_o = frame_q;

endmodule

// File: tb/tb_vga_timing_core.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_core
//
// Purpose:
//   Self-checking bench for vga_timing_core. Two small-frame instances are
//   driven in lockstep:
//     A: 13x8 frame, PIPE=2, HS_POL=1, VS_POL=0.
//     B: 7x5 frame, PIPE=0, HS_POL=0, VS_POL=1.
//   Colour and pix_en are random. A reference model tracks each instance as a
//   flat pixel index within the frame. Row and column come from division and
//   modulo. The delayed flags are the decode of the index PIPE steps earlier.
// -----------------------------------------------------------------------------
module tb_vga_timing_core;

  typedef struct {
    int ha, hfp, hsy, hbp;
    int va, vfp, vsy, vbp;
    int pipe;
    bit hpol, vpol;
  } cfg_t;

  typedef struct {
    int          pos;
    int          steps;
    logic [7:0]  frame;
    logic        refresh, hs, vs, de;
    logic [11:0] color;
  } mdl_t;

  logic        clk;
  logic        resetN;
  logic        pixEn;
  logic [11:0] colorA;
  logic [7:0]  colorB;

  logic [11:0] colorOutA;
  logic [9:0]  addrhA, addrvA;
  logic        validA, hsA, vsA, deA, refreshA;
  logic [7:0]  frameA;

  logic [7:0]  colorOutB;
  logic [9:0]  addrhB, addrvB;
  logic        validB, hsB, vsB, deB, refreshB;
  logic [7:0]  frameB;

  cfg_t cfgA, cfgB;
  mdl_t mdlA, mdlB;
  int   compared;
  int   mismatched;

  vga_timing_core #(
    .H_ACTIVE(6), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b0), .COLOR_W(12), .PIPE(2)
  ) dutA (
    .clk_i(clk), .reset_n_i(resetN), .pix_en_i(pixEn),
    .color_in_i(colorA), .color_out_o(colorOutA),
    .addrh_o(addrhA), .addrv_o(addrvA), .addr_valid_o(validA),
    .hs_o(hsA), .vs_o(vsA), .de_o(deA),
    .refresh_o(refreshA), .frame_cnt_o(frameA)
  );

  vga_timing_core #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b1), .COLOR_W(8), .PIPE(0)
  ) dutB (
    .clk_i(clk), .reset_n_i(resetN), .pix_en_i(pixEn),
    .color_in_i(colorB), .color_out_o(colorOutB),
    .addrh_o(addrhB), .addrv_o(addrvB), .addr_valid_o(validB),
    .hs_o(hsB), .vs_o(vsB), .de_o(deB),
    .refresh_o(refreshB), .frame_cnt_o(frameB)
  );

  // Free-running 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Number of pixel positions in one frame
  function automatic int frameSize(input cfg_t c);
    return (c.hsy + c.hbp + c.ha + c.hfp) * (c.vsy + c.vbp + c.va + c.vfp);
  endfunction

  // Which conditions are active at a flat pixel index
  function automatic void decodePos(input cfg_t c, input int pos,
                                    output logic hsAct, output logic vsAct, output logic deAct);
    int ht;
    int h;
    int v;
    ht    = c.hsy + c.hbp + c.ha + c.hfp;
    h     = pos % ht;
    v     = pos / ht;
    hsAct = (h < c.hsy);
    vsAct = (v < c.vsy);
    deAct = (h >= c.hsy + c.hbp) && (h < c.hsy + c.hbp + c.ha) &&
            (v >= c.vsy + c.vbp) && (v < c.vsy + c.vbp + c.va);
  endfunction

  // Visible-pixel address at a flat pixel index, or zero outside the active area
  function automatic void addrOf(input cfg_t c, input int pos,
                                 output logic valid, output int col, output int row);
    int ht;
    int h;
    int v;
    logic hsAct;
    logic vsAct;
    ht = c.hsy + c.hbp + c.ha + c.hfp;
    h  = pos % ht;
    v  = pos / ht;
    decodePos(c, pos, hsAct, vsAct, valid);
    col = valid ? h - (c.hsy + c.hbp) : 0;
    row = valid ? v - (c.vsy + c.vbp) : 0;
  endfunction

  // Expected state after one clock edge with the given inputs
  function automatic mdl_t modelStep(input cfg_t c, input mdl_t m, input logic rstN,
                                     input logic en, input logic [11:0] col);
    mdl_t n;
    int   total;
    logic h;
    logic v;
    logic d;
    n     = m;
    total = frameSize(c);
    if (!rstN) begin
      n.pos     = 0;
      n.steps   = 0;
      n.frame   = 8'd0;
      n.refresh = 1'b0;
      n.hs      = ~c.hpol;
      n.vs      = ~c.vpol;
      n.de      = 1'b0;
      n.color   = 12'd0;
    end else if (en) begin
      if (m.steps >= c.pipe) begin
        decodePos(c, (m.pos - c.pipe + total) % total, h, v, d);
      end else begin
        h = 1'b0;
        v = 1'b0;
        d = 1'b0;
      end
      n.hs      = h ? c.hpol : ~c.hpol;
      n.vs      = v ? c.vpol : ~c.vpol;
      n.de      = d;
      n.color   = d ? col : 12'd0;
      n.refresh = (m.pos == total - 1);
      if (n.refresh) n.frame = m.frame + 8'd1;
      n.pos = (m.pos + 1) % total;
      if (m.steps < 1000) n.steps = m.steps + 1;
    end else begin
      n.refresh = 1'b0;
    end
    return n;
  endfunction

  // One comparison point
  task automatic checkOne(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output of both instances against the model
  task automatic checkOutput();
    logic vA;
    logic vB;
    int   colA;
    int   rowA;
    int   colB;
    int   rowB;
    addrOf(cfgA, mdlA.pos, vA, colA, rowA);
    addrOf(cfgB, mdlB.pos, vB, colB, rowB);
    checkOne("A.color",   colorOutA,         mdlA.color);
    checkOne("A.addrh",   12'(addrhA),       12'(colA));
    checkOne("A.addrv",   12'(addrvA),       12'(rowA));
    checkOne("A.valid",   12'(validA),       12'(vA));
    checkOne("A.hs",      12'(hsA),          12'(mdlA.hs));
    checkOne("A.vs",      12'(vsA),          12'(mdlA.vs));
    checkOne("A.de",      12'(deA),          12'(mdlA.de));
    checkOne("A.refresh", 12'(refreshA),     12'(mdlA.refresh));
    checkOne("A.frame",   12'(frameA),       12'(mdlA.frame));
    checkOne("B.color",   {4'b0, colorOutB}, mdlB.color);
    checkOne("B.addrh",   12'(addrhB),       12'(colB));
    checkOne("B.addrv",   12'(addrvB),       12'(rowB));
    checkOne("B.valid",   12'(validB),       12'(vB));
    checkOne("B.hs",      12'(hsB),          12'(mdlB.hs));
    checkOne("B.vs",      12'(vsB),          12'(mdlB.vs));
    checkOne("B.de",      12'(deB),          12'(mdlB.de));
    checkOne("B.refresh", 12'(refreshB),     12'(mdlB.refresh));
    checkOne("B.frame",   12'(frameB),       12'(mdlB.frame));
  endtask

  // Drive one clock of stimulus, advance the model on the edge, check on the falling edge
  task automatic applyStimulus(input logic rstN, input logic en);
    resetN = rstN;
    pixEn  = en;
    colorA = 12'($urandom);
    colorB = 8'($urandom);
    @(posedge clk);
    mdlA = modelStep(cfgA, mdlA, rstN, en, colorA);
    mdlB = modelStep(cfgB, mdlB, rstN, en, {4'b0, colorB});
    @(negedge clk);
    checkOutput();
  endtask

  // Directed sequence of phases
  initial begin
    compared   = 0;
    mismatched = 0;
    resetN     = 1'b0;
    pixEn      = 1'b0;
    colorA     = '0;
    colorB     = '0;
    cfgA = '{ha: 6, hfp: 2, hsy: 3, hbp: 2, va: 4, vfp: 1, vsy: 2, vbp: 1,
             pipe: 2, hpol: 1'b1, vpol: 1'b0};
    cfgB = '{ha: 4, hfp: 1, hsy: 1, hbp: 1, va: 2, vfp: 1, vsy: 1, vbp: 1,
             pipe: 0, hpol: 1'b0, vpol: 1'b1};
    mdlA = '{pos: 0, steps: 0, frame: 8'd0, refresh: 1'b0, hs: 1'b0, vs: 1'b0,
             de: 1'b0, color: 12'd0};
    mdlB = mdlA;

    $display("[TB] reset, with and without pix_en");
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);

    $display("[TB] continuous pix_en");
    for (int i = 0; i < 300; i++) applyStimulus(1'b1, 1'b1);

    $display("[TB] random pix_en");
    for (int i = 0; i < 1500; i++) applyStimulus(1'b1, 1'($urandom_range(0, 1)));

    $display("[TB] mid-frame reset just before B wraps");
    for (int i = 0; i < 100 && mdlB.pos != 33; i++) applyStimulus(1'b1, 1'b1);
    checkOne("waitPos", 12'(mdlB.pos), 12'd33);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0);

    $display("[TB] long run through the frame counter wrap");
    for (int i = 0; i < 9500; i++) applyStimulus(1'b1, 1'b1);

    $display("[TB] pix_en every second clock");
    for (int i = 0; i < 2000; i++) applyStimulus(1'b1, 1'(i % 2 == 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/vga_timing_core.md
VGA_TIMING_CORE -- requirements
Module: vga_timing_core

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FP 16, H_SYNC 96, H_BP 48: horizontal front porch, sync width and back porch in pixels.
REQ-003 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 SHALL have parameters V_FP 10, V_SYNC 2, V_BP 33: vertical front porch, sync width and back porch in lines.
REQ-005 SHALL have parameters HS_POL 0 and VS_POL 0, giving the active sync level (0 = active-low).
REQ-006 SHALL have parameter COLOR_W, default 12, colour bus width.
REQ-007 SHALL have parameter PIPE, default 1, legal range 0..4: PIX_EN steps between ADDRH/ADDRV and the matching COLOR_IN.
REQ-008 CLK  in  1  single clock for all logic.
REQ-009 RESET_N  in  1  reset, synchronous to CLK, active-low.
REQ-010 PIX_EN  in  1  pixel-rate enable; all timing advances only on CLK edges where PIX_EN=1.
REQ-011 COLOR_IN  in  COLOR_W  pixel colour from the frame source.
REQ-012 COLOR_OUT  out  COLOR_W  registered colour to DAC; 0 when blanked.
REQ-013 ADDRH  out  10  active-area column, 0..H_ACTIVE-1.
REQ-014 ADDRV  out  10  active-area row, 0..V_ACTIVE-1.
REQ-015 ADDR_VALID  out  1  high when ADDRH/ADDRV address a visible pixel.
REQ-016 HS, VS  out  1 each  registered sync outputs.
REQ-017 DE  out  1  registered display enable, aligned with COLOR_OUT.
REQ-018 REFRESH  out  1  one-CLK pulse at frame wrap.
REQ-019 FRAME_CNT  out  8  frame counter.

Function
REQ-020 SHALL define H_TOTAL=H_SYNC+H_BP+H_ACTIVE+H_FP and V_TOTAL likewise; each total SHALL be no more than 2048.
REQ-021 SHALL keep hcnt in 0..H_TOTAL-1, incremented on PIX_EN and wrapping to 0 after H_TOTAL-1.
REQ-022 SHALL keep vcnt in 0..V_TOTAL-1, incremented only on PIX_EN with hcnt=H_TOTAL-1, wrapping after V_TOTAL-1.
REQ-023 SHALL use line order sync (0..H_SYNC-1), back porch, active (H_SYNC+H_BP .. +H_ACTIVE-1), front porch; vertical uses the same order.
REQ-024 SHALL drive ADDRH=hcnt-(H_SYNC+H_BP) and ADDRV=vcnt-(V_SYNC+V_BP) combinationally from the counters while in the active area, with ADDR_VALID=1; otherwise ADDRH=ADDRV=0 and ADDR_VALID=0.
REQ-025 SHALL decode raw hs/vs/de from the counters and pass them through a PIPE-deep shift register that advances only on PIX_EN.
REQ-026 On each PIX_EN edge SHALL register HS/VS/DE from the last stage (or from the raw decode when PIPE=0), driving HS=HS_POL when sync is active and !HS_POL otherwise; VS uses VS_POL the same way.
REQ-027 On each PIX_EN edge SHALL set COLOR_OUT=COLOR_IN when the last-stage de=1, else 0; total latency from counter state to outputs is PIPE+1 PIX_EN steps.
REQ-028 SHALL pulse REFRESH high for exactly one CLK on the PIX_EN edge where hcnt=H_TOTAL-1 and vcnt=V_TOTAL-1; FRAME_CNT SHALL increment on the same edge, wrapping 255->0.
REQ-029 With PIX_EN=0 SHALL hold all counters, pipeline, HS, VS, DE, COLOR_OUT and FRAME_CNT, and SHALL drive REFRESH=0.

Reset
REQ-030 RESET_N=0 at a CLK edge SHALL take priority over PIX_EN and set hcnt=vcnt=0, clear all pipeline stages to inactive, and set HS=!HS_POL, VS=!VS_POL, DE=0, COLOR_OUT=0, REFRESH=0, FRAME_CNT=0.
REQ-031 After reset release, the first PIX_EN edge SHALL register the decode of (hcnt=0, vcnt=0), or the inactive pipeline contents when PIPE>0.
REQ-032 A reset asserted mid-frame SHALL abort the frame with no REFRESH pulse and no FRAME_CNT increment.

Verification
REQ-033 Defaults, PIX_EN=1: HS low for exactly 96 of every 800 CLKs; VS low for exactly 1600 of every 420000 CLKs.
REQ-034 Defaults: DE high for 640 CLKs per line on lines 35..514 only; ADDRH=0 with ADDR_VALID=1 at hcnt=144, vcnt=35.
REQ-035 PIPE=2, COLOR_IN = ADDRH[11:0] delayed 2 PIX_EN steps: COLOR_OUT runs 0..639 while DE=1 and is 0 while DE=0.
REQ-036 PIX_EN every second CLK: line period 1600 CLKs; all outputs stable on the disabled CLKs; REFRESH stays 1 CLK wide.
REQ-037 Small parameters (H 4/1/1/1, V 2/1/1/1, totals 7x5): REFRESH every 35 CLKs; FRAME_CNT wraps 255->0 after 256 frames.
REQ-038 RESET_N low for 1 CLK at hcnt=300, vcnt=100: next CLK HS=VS=1, DE=0, FRAME_CNT=0; timing restarts at (0,0); HS_POL=1 run shows HS high during sync.
